// File: rtl/octree_pkg.sv
// +--------------------------------------------------------------------+
// | octree_pkg: shared widths and types for the octree searcher path   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package octree_pkg;

  localparam int DATA_WIDTH     = 16;
  localparam int ELEMS_PER_BEAT = 4;
  localparam int DATA_BUS_WIDTH = DATA_WIDTH * ELEMS_PER_BEAT;
  localparam int FEATURE_LENTH  = 9;
  localparam int COUNT_WIDTH    = 16;
  localparam int FIFO_DEPTH     = 2;
  localparam int FEATURE_BITS   = DATA_BUS_WIDTH * FEATURE_LENTH;

  typedef logic [FEATURE_BITS-1:0]          anchor_feat_t;
  typedef logic [$clog2(FEATURE_LENTH)-1:0] beat_idx_t;

endpackage

`default_nettype wire

// File: rtl/anchor_rec_fifo.sv
// +--------------------------------------------------------------------+
// | anchor_rec_fifo: small buffer of completed anchor feature records  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module anchor_rec_fifo
  import octree_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  anchor_feat_t din,
  output anchor_feat_t dout,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t c_depth = cnt_t'(FIFO_DEPTH);

  anchor_feat_t r_mem [FIFO_DEPTH];
  ptr_t         r_wr_ptr;
  ptr_t         r_rd_ptr;
  cnt_t         r_count;
  cnt_t         w_count_next;
  logic         w_push;
  logic         w_pop;

  assign full   = (r_count == c_depth);
  assign empty  = (r_count == '0);
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign dout   = r_mem[r_rd_ptr];

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + cnt_t'(1);
      2'b01:   w_count_next = r_count - cnt_t'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + ptr_t'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + ptr_t'(1);
      end
      r_count <= w_count_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/anchor_feature_collector.sv
// +--------------------------------------------------------------------+
// | anchor_feature_collector: reassembles feature beats into records   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module anchor_feature_collector
  import octree_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      frame_start,
  input  logic                      frame_done,
  input  logic [DATA_BUS_WIDTH-1:0] beat_data,
  input  logic                      beat_valid,
  output logic                      beat_ready,
  output anchor_feat_t              anchor_feat,
  output logic                      anchor_valid,
  input  logic                      anchor_ready,
  output logic [COUNT_WIDTH-1:0]    anchor_cnt,
  output logic                      err_partial
);

  localparam int SLOT_W = $clog2(FEATURE_LENTH - 1);
  localparam beat_idx_t c_last = beat_idx_t'(FEATURE_LENTH - 1);
  localparam logic [COUNT_WIDTH-1:0] c_cnt_max = '1;

  logic [FEATURE_LENTH-2:0][DATA_BUS_WIDTH-1:0] r_slots;
  beat_idx_t                r_beat_cnt;
  beat_idx_t                w_beat_cnt_next;
  logic                     r_beat_ready;
  logic [COUNT_WIDTH-1:0]   r_anchor_cnt;
  logic                     r_err_partial;
  logic                     w_hs;
  logic                     w_last;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_drop;
  logic                     w_fifo_full;
  logic                     w_fifo_empty;
  logic                     w_full_next;
  logic [SLOT_W-1:0]        w_slot;

  assign w_hs   = beat_valid & r_beat_ready;
  assign w_last = (r_beat_cnt == c_last);
  assign w_push = w_hs & w_last;
  assign w_pop  = anchor_valid & anchor_ready;
  assign w_drop = frame_done & (r_beat_cnt != '0) & ~w_push;
  assign w_slot = r_beat_cnt[SLOT_W-1:0];

  // Two-entry occupancy look-ahead, so beat_ready can be a flop.
  assign w_full_next = w_fifo_full ? ~w_pop : (~w_fifo_empty & w_push & ~w_pop);

  always_comb begin
    w_beat_cnt_next = r_beat_cnt;
    if (frame_start || w_drop) begin
      w_beat_cnt_next = '0;
    end else if (w_hs) begin
      w_beat_cnt_next = w_last ? '0 : r_beat_cnt + beat_idx_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slots       <= '0;
      r_beat_cnt    <= '0;
      r_beat_ready  <= 1'b1;
      r_anchor_cnt  <= '0;
      r_err_partial <= 1'b0;
    end else begin
      r_beat_cnt   <= w_beat_cnt_next;
      r_beat_ready <= !((w_beat_cnt_next == c_last) && w_full_next);
      if (w_hs && !w_last) begin
        r_slots[w_slot] <= beat_data;
      end
      if (frame_start) begin
        r_anchor_cnt <= '0;
      end else if (w_push && (r_anchor_cnt != c_cnt_max)) begin
        r_anchor_cnt <= r_anchor_cnt + 1'b1;
      end
      if (frame_start) begin
        r_err_partial <= 1'b0;
      end else if (w_drop) begin
        r_err_partial <= 1'b1;
      end
    end
  end

  anchor_rec_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .din   ({beat_data, r_slots}),
    .dout  (anchor_feat),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  assign anchor_valid = ~w_fifo_empty;
  assign beat_ready   = r_beat_ready;
  assign anchor_cnt   = r_anchor_cnt;
  assign err_partial  = r_err_partial;

endmodule

`default_nettype wire

// File: tb/tb_anchor_feature_collector.sv
// +--------------------------------------------------------------------+
// | tb_anchor_feature_collector: directed + random bench, queue model  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_anchor_feature_collector;
  import octree_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      frame_start = 1'b0;
  logic                      frame_done = 1'b0;
  logic [DATA_BUS_WIDTH-1:0] beat_data = '0;
  logic                      beat_valid = 1'b0;
  logic                      beat_ready;
  anchor_feat_t              anchor_feat;
  logic                      anchor_valid;
  logic                      anchor_ready = 1'b0;
  logic [COUNT_WIDTH-1:0]    anchor_cnt;
  logic                      err_partial;

  anchor_feature_collector dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_start  (frame_start),
    .frame_done   (frame_done),
    .beat_data    (beat_data),
    .beat_valid   (beat_valid),
    .beat_ready   (beat_ready),
    .anchor_feat  (anchor_feat),
    .anchor_valid (anchor_valid),
    .anchor_ready (anchor_ready),
    .anchor_cnt   (anchor_cnt),
    .err_partial  (err_partial)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: beats of the record in progress, queue of completed records.
  logic [DATA_BUS_WIDTH-1:0] m_part [$];
  anchor_feat_t              m_q    [$];
  int unsigned               m_cnt;
  bit                        m_err;
  bit                        m_hs;

  function automatic bit m_ready();
    return !((m_part.size() == FEATURE_LENTH - 1) && (m_q.size() == FIFO_DEPTH));
  endfunction

  task automatic model_reset();
    m_part.delete();
    m_q.delete();
    m_cnt = 0;
    m_err = 1'b0;
    m_hs  = 1'b0;
  endtask

  task automatic model_update(input bit fs, input bit fd, input bit bv,
                              input logic [DATA_BUS_WIDTH-1:0] bd, input bit ar);
    anchor_feat_t rec;
    bit completes;
    m_hs      = bv && m_ready();
    completes = m_hs && (m_part.size() == FEATURE_LENTH - 1);
    if (ar && m_q.size() > 0) void'(m_q.pop_front());
    if (completes) begin
      for (int i = 0; i < FEATURE_LENTH - 1; i++) rec[DATA_BUS_WIDTH*i +: DATA_BUS_WIDTH] = m_part[i];
      rec[FEATURE_BITS-1 -: DATA_BUS_WIDTH] = bd;
      m_q.push_back(rec);
      if (m_cnt < (2**COUNT_WIDTH) - 1) m_cnt++;
    end
    if (fs) begin
      m_part.delete();
      m_cnt = 0;
      m_err = 1'b0;
    end else if (fd && m_part.size() != 0 && !completes) begin
      m_err = 1'b1;
      m_part.delete();
    end else if (m_hs) begin
      if (completes) m_part.delete();
      else m_part.push_back(bd);
    end
  endtask

  task automatic check(input string tag, input anchor_feat_t obs, input anchor_feat_t exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("beat_ready", anchor_feat_t'(beat_ready), anchor_feat_t'(m_ready()));
    check("anchor_valid", anchor_feat_t'(anchor_valid), anchor_feat_t'(m_q.size() > 0));
    if (m_q.size() > 0) check("anchor_feat", anchor_feat, m_q[0]);
    check("anchor_cnt", anchor_feat_t'(anchor_cnt), anchor_feat_t'(m_cnt));
    check("err_partial", anchor_feat_t'(err_partial), anchor_feat_t'(m_err));
  endtask

  task automatic step(input bit fs, input bit fd, input bit bv,
                      input logic [DATA_BUS_WIDTH-1:0] bd, input bit ar);
    frame_start  = fs;
    frame_done   = fd;
    beat_valid   = bv;
    beat_data    = bd;
    anchor_ready = ar;
    @(posedge clk);
    model_update(fs, fd, bv, bd, ar);
    @(negedge clk);
    check_all();
  endtask

  // Offers consecutive beats base, base+1, ... until n are accepted or the bound expires.
  task automatic send_beats(input int n, input int base, input bit ar, input int bound);
    int accepted = 0;
    int cycles = 0;
    while (accepted < n && cycles < bound) begin
      step(1'b0, 1'b0, 1'b1, DATA_BUS_WIDTH'(base + accepted), ar);
      if (m_hs) accepted++;
      cycles++;
    end
    if (accepted < n) check("send_timeout", anchor_feat_t'(accepted), anchor_feat_t'(n));
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_feat", anchor_feat, '0);
    check_all();
    rst_n = 1'b1;
    @(negedge clk);
    check_all();

    // Single record.
    send_beats(9, 0, 1'b1, 20);
    check("single_lo", anchor_feat_t'(anchor_feat[63:0]), anchor_feat_t'(0));
    check("single_hi", anchor_feat_t'(anchor_feat[575:512]), anchor_feat_t'(8));
    check("single_cnt", anchor_feat_t'(anchor_cnt), anchor_feat_t'(1));
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Backpressure: third record's last beat must stall until a pop.
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    send_beats(26, 100, 1'b0, 40);
    check("bp_ready_low", anchor_feat_t'(beat_ready), anchor_feat_t'(0));
    step(1'b0, 1'b0, 1'b1, 64'd126, 1'b0);
    step(1'b0, 1'b0, 1'b1, 64'd126, 1'b0);
    send_beats(1, 126, 1'b1, 10);
    repeat (4) step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    check("bp_cnt", anchor_feat_t'(anchor_cnt), anchor_feat_t'(3));

    // Push and pop on the same edge with one record buffered.
    send_beats(9, 200, 1'b0, 20);
    send_beats(8, 210, 1'b0, 20);
    send_beats(1, 218, 1'b1, 10);
    check("pp_valid", anchor_feat_t'(anchor_valid), anchor_feat_t'(1));
    check("pp_head", anchor_feat_t'(anchor_feat[575:512]), anchor_feat_t'(218));
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Partial flush, clean record afterwards, then frame_start clears the flag.
    send_beats(4, 600, 1'b1, 10);
    step(1'b0, 1'b1, 1'b0, '0, 1'b1);
    check("flush_err", anchor_feat_t'(err_partial), anchor_feat_t'(1));
    send_beats(9, 700, 1'b1, 20);
    check("flush_rec", anchor_feat_t'(anchor_feat[63:0]), anchor_feat_t'(700));
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    check("fs_clear", anchor_feat_t'(err_partial), anchor_feat_t'(0));

    // frame_done together with the last beat.
    send_beats(8, 800, 1'b1, 20);
    step(1'b0, 1'b1, 1'b1, 64'd808, 1'b1);
    check("fd_last_err", anchor_feat_t'(err_partial), anchor_feat_t'(0));
    check("fd_last_valid", anchor_feat_t'(anchor_valid), anchor_feat_t'(1));
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Asynchronous reset mid-record with two records buffered.
    send_beats(21, 300, 1'b0, 40);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", anchor_feat_t'(anchor_valid), anchor_feat_t'(0));
    check("arst_cnt", anchor_feat_t'(anchor_cnt), anchor_feat_t'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
    send_beats(9, 400, 1'b1, 20);
    check("arst_rec", anchor_feat_t'(anchor_feat[63:0]), anchor_feat_t'(400));

    // Random traffic with alternating downstream pressure.
    for (int i = 0; i < 3000; i++) begin
      bit ar_bias = ((i / 200) % 2) == 1;
      step($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 3) != 0, {$urandom, $urandom},
           ar_bias ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
